shift_serializer: RTL and testbench

- Parallel-to-serial transmit stage. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, MSB-first or LSB-first, selected per word.
- Produces framing strobes (first/last) so a downstream serial consumer or deserializer can realign words.
- Contains its own hold/shift/load register plus a control FSM, bit counter and inter-word gap counter.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/ser_shreg.sv | 31 +++
 rtl/shift_serializer.sv | 133 +++++++++++++
 tb/tb_shift_serializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_pkg : shared types/constants for shift_serializer  (rev 1.0) |
// +--------------------------------------------------------------------+
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  localparam logic [1:0] HOLD = 2'd0;
  localparam logic [1:0] SHL  = 2'd1;
  localparam logic [1:0] SHR  = 2'd2;
  localparam logic [1:0] LOAD = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ser_shreg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ser_shreg : hold/shift-left/shift-right/load register   (rev 1.0)  |
// +--------------------------------------------------------------------+
module ser_shreg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      case (ctrl)
        SHL:     q <= {q[WIDTH-2:0], 1'b0};
        SHR:     q <= {1'b0, q[WIDTH-1:1]};
        LOAD:    q <= load_data;
        default: q <= q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_serializer : parallel-to-serial stage with framing (rev 1.0) |
// | Optional parity bit after the data bits: define SER_PARITY_EN.     |
// +--------------------------------------------------------------------+
module shift_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP        = 0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);
  import shift_pkg::*;

`ifdef SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
  // The IDLE accept cycle is itself one idle slot, so the GAP state
  // holds for GAP-1 cycles (at least one) to keep GAP idle cycles overall.
  localparam logic [3:0] GAP_LAST = (GAP >= 2) ? 4'(GAP - 2) : 4'd0;

  ser_state_t       state;
  logic [CW-1:0]    cnt;
  logic [3:0]       gap_cnt;
  logic             dir_r;
  logic [WIDTH-1:0] shreg;
  logic [1:0]       ctrl;
  logic             last_bit;
  logic             xfer;
  logic             data_bit;
  logic             frame_bit;

  assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);
  assign in_ready = !reset && ((state == IDLE) || (last_bit && (GAP == 0)));
  assign xfer     = in_valid && in_ready;

  always_comb begin
    ctrl = HOLD;
    if (xfer)
      ctrl = LOAD;
    else if (state == SHIFT)
      ctrl = (dir_r == DIR_LSB_FIRST) ? SHR : SHL;
  end

  ser_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .ctrl      (ctrl),
    .load_data (in_data),
    .q         (shreg)
  );

  assign data_bit = (dir_r == DIR_LSB_FIRST) ? shreg[0] : shreg[WIDTH-1];

`ifdef SER_PARITY_EN
  logic par_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      par_r <= 1'b0;
    else if (xfer)
      par_r <= (^in_data) ^ PARITY_ODD;
  end

  assign frame_bit = (cnt == CW'(WIDTH)) ? par_r : data_bit;
`else
  assign frame_bit = data_bit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      dir_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            dir_r <= in_dir;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            cnt <= '0;
            if (GAP > 0) begin
              gap_cnt <= '0;
              state   <= shift_pkg::GAP;
            end else if (xfer) begin
              dir_r <= in_dir;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        shift_pkg::GAP: begin
          if (gap_cnt >= GAP_LAST)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ser_valid = (state == SHIFT);
  assign ser_out   = ser_valid && frame_bit;
  assign ser_first = ser_valid && (cnt == '0);
  assign ser_last  = last_bit;
  assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_shift_serializer : directed bench for shift_serializer (rev 1.0)|
// +--------------------------------------------------------------------+
module tb_shift_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // DUT A (GAP=0) and DUT C (PARITY_ODD=1) share one stimulus port
  logic       a_valid = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_dir = 1'b0;
  logic       a_ready, a_out, a_sv, a_first, a_last, a_busy;

  logic       b_valid = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_dir = 1'b0;
  logic       b_ready, b_out, b_sv, b_first, b_last, b_busy;

  logic       c_ready, c_out, c_sv, c_first, c_last, c_busy;

  int sel = 0;
  logic o_ready, o_out, o_sv, o_first, o_last, o_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_serializer #(.WIDTH(8), .GAP(0), .PARITY_ODD(1'b0)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_dir(a_dir), .ser_out(a_out), .ser_valid(a_sv),
    .ser_first(a_first), .ser_last(a_last), .busy(a_busy)
  );

  shift_serializer #(.WIDTH(8), .GAP(2), .PARITY_ODD(1'b0)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_dir(b_dir), .ser_out(b_out), .ser_valid(b_sv),
    .ser_first(b_first), .ser_last(b_last), .busy(b_busy)
  );

  shift_serializer #(.WIDTH(8), .GAP(0), .PARITY_ODD(1'b1)) u_c (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(c_ready),
    .in_data(a_data), .in_dir(a_dir), .ser_out(c_out), .ser_valid(c_sv),
    .ser_first(c_first), .ser_last(c_last), .busy(c_busy)
  );

  always_comb begin
    o_ready = a_ready; o_out = a_out; o_sv = a_sv;
    o_first = a_first; o_last = a_last; o_busy = a_busy;
    if (sel == 2) begin
      o_ready = c_ready; o_out = c_out; o_sv = c_sv;
      o_first = c_first; o_last = c_last; o_busy = c_busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word on the shared A/C port and wait for the accepting edge.
  task automatic send_a(input logic [7:0] d, input logic dir);
    a_valid = 1'b1;
    a_data  = d;
    a_dir   = dir;
    @(negedge clk);
    check("ready_before_accept", o_ready, 1'b1);
    @(posedge clk);
  endtask

  // Check n serial bits (first-sent is exp[n-1]); drop valid after each frame end.
  task automatic stream(input string tag, input logic [15:0] exp, input int n, input int fr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_valid"}, o_sv, 1'b1);
      check({tag, "_bit"}, o_out, exp[n-1-i]);
      check({tag, "_first"}, o_first, (i % fr) == 0);
      check({tag, "_last"}, o_last, (i % fr) == fr - 1);
      if ((i % fr) == fr - 1)
        check({tag, "_ready_last"}, o_ready, 1'b1);
      @(posedge clk);
      if ((i % fr) == fr - 1) begin
        #1 a_valid = 1'b0;
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_idle_valid"}, o_sv, 1'b0);
    check({tag, "_idle_out"}, o_out, 1'b0);
    check({tag, "_idle_busy"}, o_busy, 1'b0);
    check({tag, "_idle_ready"}, o_ready, 1'b1);
  endtask

  initial begin
    #22 reset = 1'b0;
    @(negedge clk);
    check("rst_a_ready", a_ready, 1'b1);
    check("rst_a_valid", a_sv, 1'b0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_first", a_first, 1'b0);
    check("rst_a_last", a_last, 1'b0);
    check("rst_b_ready", b_ready, 1'b1);
    @(posedge clk); #1;

`ifndef SER_PARITY_EN
    sel = 0;
    send_a(8'h1E, 1'b0);
    #1 a_valid = 1'b0;
    stream("msb", 16'h001E, 8, 8);
    idle_check("msb");

    @(posedge clk); #1;
    send_a(8'h1E, 1'b1);
    #1 a_valid = 1'b0;
    stream("lsb", 16'h0078, 8, 8);
    idle_check("lsb");

    @(posedge clk); #1;
    send_a(8'h1E, 1'b0);
    #1 a_data = 8'hC3;
    stream("b2b", 16'h1EC3, 16, 8);
    idle_check("b2b");

    // Reset while bit 3 of 0xFF is on the line
    @(posedge clk); #1;
    send_a(8'hFF, 1'b0);
    #1 a_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_bit3", a_out, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_valid", a_sv, 1'b0);
    check("rst_mid_out", a_out, 1'b0);
    check("rst_mid_busy", a_busy, 1'b0);
    #5 reset = 1'b0;
    @(posedge clk); #1;
    send_a(8'h81, 1'b0);
    #1 a_valid = 1'b0;
    stream("post_rst", 16'h0081, 8, 8);
    idle_check("post_rst");

    // GAP=2 DUT: two words queued, third held off until the second gap ends
    @(posedge clk); #1;
    b_valid = 1'b1; b_data = 8'h1E; b_dir = 1'b0;
    @(posedge clk); #1;
    b_data = 8'hC3;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check("gap_valid", b_sv, 1'b1);
        check("gap_bit", b_out, (w == 0) ? 8'h1E >> (7 - i) & 8'h01 : 8'hC3 >> (7 - i) & 8'h01);
        check("gap_ready_in_frame", b_ready, 1'b0);
        @(posedge clk);
      end
      @(negedge clk);
      check("gap0_valid", b_sv, 1'b0);
      check("gap0_ready", b_ready, 1'b0);
      check("gap0_busy", b_busy, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("gap1_valid", b_sv, 1'b0);
      check("gap1_ready", b_ready, 1'b1);
      @(posedge clk); #1;
      if (w == 0) b_data = 8'h55;
      else b_valid = 1'b0;
    end
    @(negedge clk);
    check("third_valid", b_sv, 1'b1);
    check("third_first", b_first, 1'b1);
    check("third_bit0", b_out, 1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("b_drain_busy", b_busy, 1'b0);
`else
    sel = 0;
    send_a(8'h07, 1'b0);
    #1 a_valid = 1'b0;
    stream("par_even7", 16'h000F, 9, 9);
    idle_check("par_even7");

    @(posedge clk); #1;
    send_a(8'h03, 1'b0);
    #1 a_valid = 1'b0;
    stream("par_even3", 16'h0006, 9, 9);
    idle_check("par_even3");

    @(posedge clk); #1;
    sel = 2;
    send_a(8'h03, 1'b0);
    #1 a_valid = 1'b0;
    stream("par_odd3", 16'h0007, 9, 9);
    idle_check("par_odd3");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
